// File: rtl/result_readback_pkg.sv
// Shared widths, readback FSM encoding and the ReLU clamp helper for the
// result-RAM readback slice (optional clamp enabled by RESULT_RELU_EN).
package result_readback_pkg;
  localparam int ADDR_SIZE   = 8;
  localparam int RESULT_SIZE = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rb_state_e;

  function automatic logic [RESULT_SIZE-1:0] relu_clamp(input logic [RESULT_SIZE-1:0] word);
    logic [RESULT_SIZE-1:0] res;
    if (word[RESULT_SIZE-1]) begin
      res = {RESULT_SIZE{1'b0}};
    end else begin
      res = word;
    end
    return res;
  endfunction
endpackage

// File: rtl/result_readback_if.sv
// Bundle of the writer trigger, result-RAM read port and output stream of
// result_readback; master is the readback engine, slave its surroundings.
interface result_readback_if;
  import result_readback_pkg::*;

  logic                   w_done;
  logic [ADDR_SIZE-1:0]   result_count;
  logic [ADDR_SIZE-1:0]   base_addr;
  logic                   rd_en;
  logic [ADDR_SIZE-1:0]   rd_addr;
  logic [RESULT_SIZE-1:0] rd_data;
  logic [RESULT_SIZE-1:0] o_data;
  logic                   o_valid;
  logic                   i_ready;
  logic                   o_last;
  logic                   o_busy;
  logic                   o_read_done;

  modport master (
    input  w_done, result_count, base_addr, rd_data, i_ready,
    output rd_en, rd_addr, o_data, o_valid, o_last, o_busy, o_read_done
  );

  modport slave (
    output w_done, result_count, base_addr, rd_data, i_ready,
    input  rd_en, rd_addr, o_data, o_valid, o_last, o_busy, o_read_done
  );
endinterface

// File: rtl/result_readback_fifo.sv
// result_fifo: synchronous skid FIFO with combinational head, used to absorb
// result-RAM read returns while the downstream stalls.
module result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             wr_s, rd_s;

  assign empty = (count_r == {CW{1'b0}});
  assign full  = (count_r == CNT_MAX);
  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];
  assign wr_s  = push & ~full;
  assign rd_s  = pop & ~empty;

  // Storage, pointers and occupancy; a simultaneous push and pop keeps count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (wr_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_s, rd_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/result_readback.sv
// result_readback: streams the result RAM out in address order after w_done,
// hiding read latency behind a credit-controlled skid FIFO (RESULT_RELU_EN clamps negatives).
module result_readback
  import result_readback_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  result_readback_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_SIZE-1:0] ADDR_ONE  = ADDR_SIZE'(1'b1);
  localparam logic [ADDR_SIZE-1:0] ADDR_ZERO = {ADDR_SIZE{1'b0}};
  localparam logic [CW:0]          DEPTH_W   = (CW + 1)'(FIFO_DEPTH);

  rb_state_e              state_r, state_s;
  logic [ADDR_SIZE-1:0]   count_r, base_r, issued_r, accepted_r, accepted_next_s;
  logic [RD_LATENCY-1:0]  sr_r;
  logic [CW:0]            inflight_s, slots_s;
  logic [CW-1:0]          fifo_count_s;
  logic                   fifo_empty_s, fifo_full_s;
  logic                   push_s, pop_s, issue_s;
  logic [RESULT_SIZE-1:0] push_data_s, head_s;
  logic                   rd_en_s, o_busy_s, o_read_done_s, o_last_s;
  logic [ADDR_SIZE-1:0]   rd_addr_s;

  // Credit check, handshake and FIFO write data.
  always_comb begin
    inflight_s = {(CW + 1){1'b0}};
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight_s = inflight_s + (CW + 1)'(sr_r[i]);
    end
    pop_s  = ~fifo_empty_s & bus.i_ready;
    push_s = sr_r[RD_LATENCY-1] & ~fifo_full_s;
    // A word leaving this cycle frees its slot, which keeps 1/cycle at DEPTH = LATENCY+1.
    slots_s = {1'b0, fifo_count_s} + inflight_s - (CW + 1)'(pop_s);
    issue_s = (state_r == ST_READ) && (issued_r != count_r) && (slots_s < DEPTH_W);
    if (pop_s) begin
      accepted_next_s = accepted_r + ADDR_ONE;
    end else begin
      accepted_next_s = accepted_r;
    end
`ifdef RESULT_RELU_EN
    push_data_s = relu_clamp(bus.rd_data);
`else
    push_data_s = bus.rd_data;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state; an empty run takes one DRAIN cycle so o_read_done lands at T+2.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.w_done) begin
          if (bus.result_count == ADDR_ZERO) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_READ;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (issue_s && ((issued_r + ADDR_ONE) == count_r)) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (accepted_next_s == count_r) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    rd_en_s       = issue_s;
    o_busy_s      = (state_r != ST_IDLE);
    o_read_done_s = (state_r == ST_DONE);
    o_last_s      = ~fifo_empty_s && (accepted_r == (count_r - ADDR_ONE));
    if (issue_s) begin
      rd_addr_s = base_r + issued_r;
    end else begin
      rd_addr_s = ADDR_ZERO;
    end
  end

  // Run parameters and issue/accept counters; w_done only latches in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r    <= ADDR_ZERO;
      base_r     <= ADDR_ZERO;
      issued_r   <= ADDR_ZERO;
      accepted_r <= ADDR_ZERO;
    end else if ((state_r == ST_IDLE) && bus.w_done) begin
      count_r    <= bus.result_count;
      base_r     <= bus.base_addr;
      issued_r   <= ADDR_ZERO;
      accepted_r <= ADDR_ZERO;
    end else begin
      if (issue_s) begin
        issued_r <= issued_r + ADDR_ONE;
      end
      accepted_r <= accepted_next_s;
    end
  end

  // Read-latency valid shift register; the exiting bit is the FIFO push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_r <= {RD_LATENCY{1'b0}};
    end else begin
      sr_r[0] <= issue_s;
      for (int i = 1; i < RD_LATENCY; i++) begin
        sr_r[i] <= sr_r[i-1];
      end
    end
  end

  result_fifo #(
    .WIDTH (RESULT_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s),
    .full      (fifo_full_s)
  );

  assign bus.rd_en       = rd_en_s;
  assign bus.rd_addr     = rd_addr_s;
  assign bus.o_data      = head_s;
  assign bus.o_valid     = ~fifo_empty_s;
  assign bus.o_last      = o_last_s;
  assign bus.o_busy      = o_busy_s;
  assign bus.o_read_done = o_read_done_s;
endmodule

// File: tb/tb_result_readback.sv
// Bench for result_readback: three instances (RD_LATENCY 1..3) share stimulus
// and each output stream is compared against a model built from the RAM contents.
module tb_result_readback;
  import result_readback_pkg::*;

  typedef struct {
    logic [ADDR_SIZE-1:0] base;
    int                   count;
    int                   ready_pct;
    int                   mode;
    int                   extra_wd;
    int                   exp_words;
    logic [ADDR_SIZE-1:0] exp_last_addr;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 w_done = 1'b0;
  logic [ADDR_SIZE-1:0] result_count = '0;
  logic [ADDR_SIZE-1:0] base_addr = '0;
  logic                 ready = 1'b0;
  logic                 clr = 1'b0;
  int                   ram_mode = 0;
  int                   cyc = 0;
  int                   n_checks = 0;
  int                   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM contents: 0 = identity, 1 = signed table (-5, 7, 0, -1), 2 = scrambled.
  function automatic logic [RESULT_SIZE-1:0] ram_word(input int mode, input logic [ADDR_SIZE-1:0] a);
    logic [RESULT_SIZE-1:0] w;
    case (mode)
      1: begin
        case (a[1:0])
          2'd0:    w = 16'hFFFB;
          2'd1:    w = 16'h0007;
          2'd2:    w = 16'h0000;
          default: w = 16'hFFFF;
        endcase
      end
      2:       w = {a ^ 8'hA5, a};
      default: w = {8'h00, a};
    endcase
    return w;
  endfunction

  function automatic logic [RESULT_SIZE-1:0] exp_word(input int mode, input logic [ADDR_SIZE-1:0] a);
    logic [RESULT_SIZE-1:0] w;
    w = ram_word(mode, a);
`ifdef RESULT_RELU_EN
    if (w[RESULT_SIZE-1]) w = '0;
`endif
    return w;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_lat
    localparam int LAT = g + 1;
    result_readback_if bus();
    logic [ADDR_SIZE-1:0]   a_pipe [LAT];
    int                     done_cnt = 0, done_cyc = -1, last_hs = -1;
    int                     first_rd = -1, first_v = -1, busy_cnt = 0, stall_err = 0;
    logic [RESULT_SIZE-1:0] out_q[$];
    logic                   last_q[$];
    logic [ADDR_SIZE-1:0]   addr_q[$];
    logic                   prev_stall = 1'b0;
    logic [RESULT_SIZE:0]   prev_word = '0;

    assign bus.w_done       = w_done;
    assign bus.result_count = result_count;
    assign bus.base_addr    = base_addr;
    assign bus.i_ready      = ready;
    assign bus.rd_data      = ram_word(ram_mode, a_pipe[LAT-1]);

    always @(posedge clk) begin
      a_pipe[0] <= bus.rd_addr;
      for (int i = 1; i < LAT; i++) a_pipe[i] <= a_pipe[i-1];
    end

    result_readback #(.RD_LATENCY(LAT), .FIFO_DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    always @(negedge clk) begin
      if (clr) begin
        done_cnt <= 0; done_cyc <= -1; last_hs <= -1; first_rd <= -1; first_v <= -1;
        busy_cnt <= 0; stall_err <= 0; prev_stall <= 1'b0;
        out_q.delete(); last_q.delete(); addr_q.delete();
      end else begin
        if (bus.rd_en) begin
          addr_q.push_back(bus.rd_addr);
          if (first_rd < 0) first_rd <= cyc;
        end
        if (bus.o_valid && first_v < 0) first_v <= cyc;
        if (bus.o_busy) busy_cnt <= busy_cnt + 1;
        if (bus.o_read_done) begin
          done_cnt <= done_cnt + 1;
          done_cyc <= cyc;
        end
        if (prev_stall && (!bus.o_valid || {bus.o_last, bus.o_data} != prev_word))
          stall_err <= stall_err + 1;
        if (bus.o_valid && bus.i_ready) begin
          out_q.push_back(bus.o_data);
          last_q.push_back(bus.o_last);
          last_hs <= cyc;
        end
        prev_stall <= bus.o_valid && !bus.i_ready;
        prev_word  <= {bus.o_last, bus.o_data};
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v, output int t0);
    int n;
    clr = 1'b1; ready = 1'b0; tick; clr = 1'b0;
    result_count = ADDR_SIZE'(v.count); base_addr = v.base; ram_mode = v.mode;
    w_done = 1'b1; t0 = cyc; tick; w_done = 1'b0;
    n = 0;
    while (!(g_lat[0].done_cnt > 0 && g_lat[1].done_cnt > 0 && g_lat[2].done_cnt > 0) && n < 3000) begin
      ready = ($urandom_range(0, 99) < v.ready_pct);
      if (v.extra_wd != 0 && n + 1 == v.extra_wd) begin
        w_done = 1'b1; result_count = 8'd7; base_addr = 8'h99;
      end else begin
        w_done = 1'b0;
      end
      tick;
      n++;
    end
    w_done = 1'b0;
    if (n >= 3000) chk("txn_timeout", 32'(n), 32'd0);
    ready = 1'b1;
    repeat (4) tick;
  endtask

  task automatic check_inst(input int lat, input vec_t v, input int t0,
                            input logic [RESULT_SIZE-1:0] oq[$], input logic lq[$],
                            input logic [ADDR_SIZE-1:0] aq[$], input int dcnt, input int dcyc,
                            input int lhs, input int frd, input int fv, input int bcnt, input int serr);
    string p;
    p = $sformatf("L%0d_b%02h_n%0d", lat, v.base, v.count);
    chk({p, "_words"}, oq.size(), v.exp_words);
    chk({p, "_reads"}, aq.size(), v.count);
    for (int i = 0; i < v.count; i++) begin
      logic [ADDR_SIZE-1:0] a;
      a = v.base + ADDR_SIZE'(i);
      if (i < aq.size()) chk($sformatf("%s_addr%0d", p, i), aq[i], a);
      if (i < oq.size()) begin
        chk($sformatf("%s_data%0d", p, i), oq[i], exp_word(v.mode, a));
        chk($sformatf("%s_last%0d", p, i), lq[i], (i == v.count - 1));
      end
    end
    chk({p, "_done_pulses"}, dcnt, 1);
    chk({p, "_stall_stable"}, serr, 0);
    chk({p, "_busy_span"}, bcnt, dcyc - t0);
    if (v.count == 0) begin
      chk({p, "_zero_done_at"}, dcyc - t0, 2);
      chk({p, "_zero_no_valid"}, fv, -1);
    end else begin
      chk({p, "_first_rd_en"}, frd - t0, 1);
      chk({p, "_first_valid"}, fv - t0, 2 + lat);
      chk({p, "_done_after_last"}, dcyc - lhs, 1);
      if (aq.size() > 0) chk({p, "_last_addr"}, aq[aq.size()-1], v.exp_last_addr);
      if (v.ready_pct == 100) chk({p, "_throughput"}, lhs - fv, v.count - 1);
    end
  endtask

  task automatic check_all(input vec_t v, input int t0);
    check_inst(1, v, t0, g_lat[0].out_q, g_lat[0].last_q, g_lat[0].addr_q, g_lat[0].done_cnt,
               g_lat[0].done_cyc, g_lat[0].last_hs, g_lat[0].first_rd, g_lat[0].first_v,
               g_lat[0].busy_cnt, g_lat[0].stall_err);
    check_inst(2, v, t0, g_lat[1].out_q, g_lat[1].last_q, g_lat[1].addr_q, g_lat[1].done_cnt,
               g_lat[1].done_cyc, g_lat[1].last_hs, g_lat[1].first_rd, g_lat[1].first_v,
               g_lat[1].busy_cnt, g_lat[1].stall_err);
    check_inst(3, v, t0, g_lat[2].out_q, g_lat[2].last_q, g_lat[2].addr_q, g_lat[2].done_cnt,
               g_lat[2].done_cyc, g_lat[2].last_hs, g_lat[2].first_rd, g_lat[2].first_v,
               g_lat[2].busy_cnt, g_lat[2].stall_err);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_L1"}, {g_lat[0].bus.rd_en, g_lat[0].bus.rd_addr, g_lat[0].bus.o_data, g_lat[0].bus.o_valid,
                      g_lat[0].bus.o_last, g_lat[0].bus.o_busy, g_lat[0].bus.o_read_done}, 32'h0);
    chk({nm, "_L2"}, {g_lat[1].bus.rd_en, g_lat[1].bus.rd_addr, g_lat[1].bus.o_data, g_lat[1].bus.o_valid,
                      g_lat[1].bus.o_last, g_lat[1].bus.o_busy, g_lat[1].bus.o_read_done}, 32'h0);
    chk({nm, "_L3"}, {g_lat[2].bus.rd_en, g_lat[2].bus.rd_addr, g_lat[2].bus.o_data, g_lat[2].bus.o_valid,
                      g_lat[2].bus.o_last, g_lat[2].bus.o_busy, g_lat[2].bus.o_read_done}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vec_t rv;
    int   t0;
    int   n;

    vecs[0] = '{base: 8'h10, count: 8,  ready_pct: 100, mode: 0, extra_wd: 0, exp_words: 8,  exp_last_addr: 8'h17};
    vecs[1] = '{base: 8'h00, count: 16, ready_pct: 50,  mode: 2, extra_wd: 0, exp_words: 16, exp_last_addr: 8'h0F};
    vecs[2] = '{base: 8'h33, count: 16, ready_pct: 30,  mode: 2, extra_wd: 0, exp_words: 16, exp_last_addr: 8'h42};
    vecs[3] = '{base: 8'hFE, count: 4,  ready_pct: 100, mode: 0, extra_wd: 0, exp_words: 4,  exp_last_addr: 8'h01};
    vecs[4] = '{base: 8'h80, count: 16, ready_pct: 70,  mode: 2, extra_wd: 0, exp_words: 16, exp_last_addr: 8'h8F};
    vecs[5] = '{base: 8'h00, count: 4,  ready_pct: 60,  mode: 1, extra_wd: 3, exp_words: 4,  exp_last_addr: 8'h03};
    vecs[6] = '{base: 8'h05, count: 0,  ready_pct: 100, mode: 0, extra_wd: 0, exp_words: 0,  exp_last_addr: 8'h00};

    rst = 1'b1;
    repeat (3) tick;
    check_reset_outputs("reset_values");
    rst = 1'b0;
    tick;

    for (int k = 0; k < 7; k++) begin
      run_txn(vecs[k], t0);
      check_all(vecs[k], t0);
    end

    // Reset in the middle of a 12-word run, then a fresh 3-word run.
    clr = 1'b1; ready = 1'b1; tick; clr = 1'b0;
    result_count = 8'd12; base_addr = 8'h20; ram_mode = 0;
    w_done = 1'b1; tick; w_done = 1'b0;
    n = 0;
    while (g_lat[0].out_q.size() < 5 && n < 200) begin
      tick;
      n++;
    end
    chk("rst_mid_reached_5_words", (g_lat[0].out_q.size() >= 5), 32'd1);
    chk("rst_mid_reads_in_flight", (g_lat[0].addr_q.size() > g_lat[0].out_q.size()), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid_outputs");
    tick;
    tick;
    rst = 1'b0;
    tick;
    rv = '{base: 8'h60, count: 3, ready_pct: 100, mode: 0, extra_wd: 0, exp_words: 3, exp_last_addr: 8'h62};
    run_txn(rv, t0);
    check_all(rv, t0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
